// File: rtl/load_hazard_ctrl.sv
// load_hazard_ctrl
// Issue-side interlock between ID and EX. It tracks which registers are still
// waiting on outstanding load data. It stalls ID when an operand or the
// destination is still waiting, or when the outstanding-load limit is reached.
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_id_valid, i_flush       ID instruction valid / squashed this cycle
//   i_r{m,n,s}_use/_code      operand reads of the ID instruction
//   i_rd_en, i_rd_code        destination write of the ID instruction
//   i_is_load                 destination is written late by load data
//   i_ld_done, i_ld_code      load data on the WB write port this cycle
//   o_stall, o_issue          interlock decision for the ID instruction
//   o_pending                 per-register pending-load bits
//   o_ld_count                number of outstanding loads
//   o_err                     sticky: load completion for a non-pending register
//   o_stall_cycles            saturating stall-cycle counter
module load_hazard_ctrl #(
  parameter int MAX_LD = 2,
  parameter int CNT_W  = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_id_valid,
  input  logic             i_flush,
  input  logic             i_rm_use,
  input  logic             i_rn_use,
  input  logic             i_rs_use,
  input  logic [3:0]       i_rm_code,
  input  logic [3:0]       i_rn_code,
  input  logic [3:0]       i_rs_code,
  input  logic             i_rd_en,
  input  logic [3:0]       i_rd_code,
  input  logic             i_is_load,
  input  logic             i_ld_done,
  input  logic [3:0]       i_ld_code,
  output logic             o_stall,
  output logic             o_issue,
  output logic [15:0]      o_pending,
  output logic [CNT_W-1:0] o_ld_count,
  output logic             o_err,
  output logic [15:0]      o_stall_cycles
);

  logic [15:0]      pending_q, pending_d;
  logic [CNT_W-1:0] ld_count_q, ld_count_d;
  logic             err_q, err_d;
  logic [15:0]      stall_cycles_q, stall_cycles_d;

  logic [15:0] clr;
  logic [15:0] busy;
  logic [15:0] set_mask;
  logic        raw, waw, cap;
  logic        stall, issue;
  logic        ld_issue;
  logic        done_ok;

  always_comb begin
    clr      = '0;
    busy     = '0;
    set_mask = '0;
    raw      = 1'b0;
    waw      = 1'b0;
    cap      = 1'b0;
    stall    = 1'b0;
    issue    = 1'b0;
    ld_issue = 1'b0;
    done_ok  = 1'b0;

    if (i_ld_done) begin
      clr = 16'(1) << i_ld_code;
    end
    // Data returning on WB this cycle is forwarded, so it no longer blocks.
    busy = pending_q & ~clr;

    raw = (i_rm_use & busy[i_rm_code]) |
          (i_rn_use & busy[i_rn_code]) |
          (i_rs_use & busy[i_rs_code]);
    waw = i_rd_en & busy[i_rd_code];
    // A completion this cycle frees a slot for the new load.
    cap = i_is_load & i_rd_en & (ld_count_q == CNT_W'(MAX_LD)) & ~i_ld_done;

    stall = i_id_valid & ~i_flush & (raw | waw | cap);
    issue = i_id_valid & ~i_flush & ~stall;

    ld_issue = issue & i_is_load & i_rd_en;
    if (ld_issue) begin
      set_mask = 16'(1) << i_rd_code;
    end
    done_ok = i_ld_done & pending_q[i_ld_code] & (ld_count_q != '0);
  end

  always_comb begin
    // Set after clear so a same-cycle reissue to the same register wins.
    pending_d = (pending_q & ~clr) | set_mask;

    ld_count_d = ld_count_q;
    if (ld_issue && !done_ok) begin
      ld_count_d = ld_count_q + CNT_W'(1);
    end else if (!ld_issue && done_ok) begin
      ld_count_d = ld_count_q - CNT_W'(1);
    end

    err_d = err_q | (i_ld_done & ~done_ok);

    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pending_q      <= '0;
      ld_count_q     <= '0;
      err_q          <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      pending_q      <= pending_d;
      ld_count_q     <= ld_count_d;
      err_q          <= err_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign o_stall        = stall;
  assign o_issue        = issue;
  assign o_pending      = pending_q;
  assign o_ld_count     = ld_count_q;
  assign o_err          = err_q;
  assign o_stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_load_hazard_ctrl.sv
module tb_load_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic        id_valid, flush;
  logic        rm_use, rn_use, rs_use;
  logic [3:0]  rm_code, rn_code, rs_code;
  logic        rd_en;
  logic [3:0]  rd_code;
  logic        is_load;
  logic        ld_done;
  logic [3:0]  ld_code;
  logic        stall, issue;
  logic [15:0] pending;
  logic [2:0]  ld_count;
  logic        err;
  logic [15:0] stall_cycles;

  int unsigned checks;
  int unsigned errors;
  logic [15:0] exp_sc;

  load_hazard_ctrl #(.MAX_LD(2), .CNT_W(3)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid), .i_flush(flush),
    .i_rm_use(rm_use), .i_rn_use(rn_use), .i_rs_use(rs_use),
    .i_rm_code(rm_code), .i_rn_code(rn_code), .i_rs_code(rs_code),
    .i_rd_en(rd_en), .i_rd_code(rd_code), .i_is_load(is_load),
    .i_ld_done(ld_done), .i_ld_code(ld_code),
    .o_stall(stall), .o_issue(issue), .o_pending(pending),
    .o_ld_count(ld_count), .o_err(err), .o_stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    id_valid = 0; flush = 0; rm_use = 0; rn_use = 0; rs_use = 0;
    rm_code = 0; rn_code = 0; rs_code = 0; rd_en = 0; rd_code = 0;
    is_load = 0; ld_done = 0; ld_code = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_load(input logic [3:0] r);
    idle_inputs();
    id_valid = 1; rd_en = 1; rd_code = r; is_load = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #3;
    checks++;
    if (pending !== 16'h0 || ld_count !== 3'd0 || err !== 1'b0 || stall_cycles !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: pending=%h cnt=%0d err=%b sc=%0d required 0/0/0/0",
               pending, ld_count, err, stall_cycles);
    end
    checks++;
    if (stall !== 1'b0 || issue !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: stall=%b issue=%b required 0/0", stall, issue);
    end
    tick();
    rst_n = 1;
    tick();
    exp_sc = 0;
  endtask

  task automatic test_raw_stall();
    put_load(4'd3);
    #2;
    checks++;
    if (issue !== 1'b1 || stall !== 1'b0) begin
      errors++;
      $display("FAIL raw_load_issue: issue=%b stall=%b required 1/0", issue, stall);
    end
    tick();
    checks++;
    if (pending !== 16'h0008 || ld_count !== 3'd1) begin
      errors++;
      $display("FAIL raw_pending_set: pending=%h cnt=%0d required 0008/1", pending, ld_count);
    end
    idle_inputs();
    id_valid = 1; rn_use = 1; rn_code = 4'd3; rd_en = 1; rd_code = 4'd6;
    for (int c = 1; c <= 3; c++) begin
      #2;
      checks++;
      if (stall !== 1'b1 || issue !== 1'b0) begin
        errors++;
        $display("FAIL raw_stall_c%0d: stall=%b issue=%b required 1/0", c, stall, issue);
      end
      exp_sc++;
      tick();
    end
    ld_done = 1; ld_code = 4'd3;
    #2;
    checks++;
    if (stall !== 1'b0 || issue !== 1'b1) begin
      errors++;
      $display("FAIL raw_issue_on_done: stall=%b issue=%b required 0/1", stall, issue);
    end
    tick();
    idle_inputs();
    checks++;
    if (pending !== 16'h0 || ld_count !== 3'd0 || stall_cycles !== 16'd3) begin
      errors++;
      $display("FAIL raw_after: pending=%h cnt=%0d sc=%0d required 0000/0/3",
               pending, ld_count, stall_cycles);
    end
  endtask

  task automatic test_ld_cap();
    put_load(4'd1);
    tick();
    put_load(4'd2);
    tick();
    checks++;
    if (pending !== 16'h0006 || ld_count !== 3'd2) begin
      errors++;
      $display("FAIL cap_fill: pending=%h cnt=%0d required 0006/2", pending, ld_count);
    end
    put_load(4'd4);
    #2;
    checks++;
    if (stall !== 1'b1 || issue !== 1'b0) begin
      errors++;
      $display("FAIL cap_stall: stall=%b issue=%b required 1/0", stall, issue);
    end
    exp_sc++;
    tick();
    ld_done = 1; ld_code = 4'd1;
    #2;
    checks++;
    if (stall !== 1'b0 || issue !== 1'b1) begin
      errors++;
      $display("FAIL cap_issue_on_done: stall=%b issue=%b required 0/1", stall, issue);
    end
    tick();
    checks++;
    if (pending !== 16'h0014 || ld_count !== 3'd2) begin
      errors++;
      $display("FAIL cap_swap: pending=%h cnt=%0d required 0014/2", pending, ld_count);
    end
    idle_inputs();
    ld_done = 1; ld_code = 4'd2;
    tick();
    ld_code = 4'd4;
    tick();
    idle_inputs();
    checks++;
    if (pending !== 16'h0 || ld_count !== 3'd0 || err !== 1'b0) begin
      errors++;
      $display("FAIL cap_drain: pending=%h cnt=%0d err=%b required 0000/0/0", pending, ld_count, err);
    end
  endtask

  task automatic test_same_cycle();
    put_load(4'd5);
    tick();
    put_load(4'd5);
    #2;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL waw_stall: stall=%b required 1", stall);
    end
    exp_sc++;
    tick();
    ld_done = 1; ld_code = 4'd5;
    #2;
    checks++;
    if (stall !== 1'b0 || issue !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle_issue: stall=%b issue=%b required 0/1", stall, issue);
    end
    tick();
    idle_inputs();
    checks++;
    if (pending !== 16'h0020 || ld_count !== 3'd1) begin
      errors++;
      $display("FAIL same_cycle_state: pending=%h cnt=%0d required 0020/1", pending, ld_count);
    end
    ld_done = 1; ld_code = 4'd5;
    tick();
    idle_inputs();
    checks++;
    if (pending !== 16'h0 || ld_count !== 3'd0 || stall_cycles !== exp_sc) begin
      errors++;
      $display("FAIL same_cycle_drain: pending=%h cnt=%0d sc=%0d required 0000/0/%0d",
               pending, ld_count, stall_cycles, exp_sc);
    end
  endtask

  task automatic test_err();
    idle_inputs();
    ld_done = 1; ld_code = 4'd7;
    tick();
    idle_inputs();
    checks++;
    if (err !== 1'b1 || ld_count !== 3'd0 || pending !== 16'h0) begin
      errors++;
      $display("FAIL err_set: err=%b cnt=%0d pending=%h required 1/0/0000", err, ld_count, pending);
    end
    tick();
    tick();
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: err=%b required 1", err);
    end
  endtask

  task automatic test_flush();
    put_load(4'd9);
    tick();
    idle_inputs();
    id_valid = 1; rm_use = 1; rm_code = 4'd9; flush = 1;
    #2;
    checks++;
    if (stall !== 1'b0 || issue !== 1'b0) begin
      errors++;
      $display("FAIL flush_outputs: stall=%b issue=%b required 0/0", stall, issue);
    end
    tick();
    checks++;
    if (pending !== 16'h0200 || ld_count !== 3'd1 || stall_cycles !== exp_sc) begin
      errors++;
      $display("FAIL flush_retain: pending=%h cnt=%0d sc=%0d required 0200/1/%0d",
               pending, ld_count, stall_cycles, exp_sc);
    end
    idle_inputs();
    id_valid = 1; rs_use = 1; rs_code = 4'd9;
    #2;
    checks++;
    if (stall !== 1'b1 || issue !== 1'b0) begin
      errors++;
      $display("FAIL rs_stall: stall=%b issue=%b required 1/0", stall, issue);
    end
    exp_sc++;
    tick();
  endtask

  task automatic test_async_reset();
    put_load(4'd10);
    tick();
    idle_inputs();
    checks++;
    if (pending !== 16'h0600 || ld_count !== 3'd2 || stall_cycles !== exp_sc) begin
      errors++;
      $display("FAIL pre_reset: pending=%h cnt=%0d sc=%0d required 0600/2/%0d",
               pending, ld_count, stall_cycles, exp_sc);
    end
    #2;
    rst_n = 0;
    #1;
    checks++;
    if (pending !== 16'h0 || ld_count !== 3'd0 || err !== 1'b0 || stall_cycles !== 16'h0) begin
      errors++;
      $display("FAIL async_reset: pending=%h cnt=%0d err=%b sc=%0d required 0/0/0/0",
               pending, ld_count, err, stall_cycles);
    end
    tick();
    rst_n = 1;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_sc = 0;
    rst_n  = 0;
    idle_inputs();
    test_reset();
    test_raw_stall();
    test_ld_cap();
    test_same_cycle();
    test_err();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
